// File: rtl/load_store_unit.sv
// Load/store unit: checks legality and alignment of one access at a time, drives a
// word-aligned byte-strobed data-memory transaction and returns extended load data.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned ADDR_WIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic                  stall,
    output logic                  resp_valid,
    output logic [31:0]           resp_data,
    output logic [1:0]            fault,
    output logic                  dmem_req_valid,
    input  logic                  dmem_req_ready,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [31:0]           dmem_wdata,
    output logic [3:0]            dmem_wstrb,
    input  logic                  dmem_rsp_valid,
    input  logic [31:0]           dmem_rdata
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    localparam logic [1:0] F_OK       = 2'b00;
    localparam logic [1:0] F_MISALIGN = 2'b01;
    localparam logic [1:0] F_ILLEGAL  = 2'b10;
    localparam logic [1:0] F_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

    state_e                  state_q, state_d;
    logic                    is_load_q, is_load_d;
    logic [2:0]              funct3_q, funct3_d;
    logic [1:0]              addr_lo_q, addr_lo_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    req_ready_q, req_ready_d;
    logic                    stall_q, stall_d;
    logic                    resp_valid_q, resp_valid_d;
    logic [31:0]             resp_data_q, resp_data_d;
    logic [1:0]              fault_q, fault_d;
    logic                    dmem_req_valid_q, dmem_req_valid_d;
    logic                    dmem_we_q, dmem_we_d;
    logic [ADDR_WIDTH-1:0]   dmem_addr_q, dmem_addr_d;
    logic [31:0]             dmem_wdata_q, dmem_wdata_d;
    logic [3:0]              dmem_wstrb_q, dmem_wstrb_d;

    logic                    illegal_c;
    logic                    misaligned_c;
    logic [31:0]             lane_c;
    logic [31:0]             load_ext_c;

    // Request legality and alignment, evaluated on the incoming request
    always_comb begin
        illegal_c = 1'b0;
        if (mem_read && mem_write) begin
            illegal_c = 1'b1;
        end else if (mem_read) begin
            illegal_c = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        end else if (mem_write) begin
            illegal_c = (funct3 != 3'b000) && (funct3 != 3'b001) && (funct3 != 3'b010);
        end
        misaligned_c = ((funct3[1:0] == 2'b01) && addr[0]) ||
                       ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    end

    // Lane select and extension of the returned read word
    always_comb begin
        lane_c = dmem_rdata >> {addr_lo_q, 3'b000};
        case (funct3_q)
            3'b000:  load_ext_c = {{24{lane_c[7]}}, lane_c[7:0]};
            3'b001:  load_ext_c = {{16{lane_c[15]}}, lane_c[15:0]};
            3'b100:  load_ext_c = {24'h000000, lane_c[7:0]};
            3'b101:  load_ext_c = {16'h0000, lane_c[15:0]};
            default: load_ext_c = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d          = state_q;
        is_load_d        = is_load_q;
        funct3_d         = funct3_q;
        addr_lo_d        = addr_lo_q;
        cnt_d            = '0;
        resp_valid_d     = 1'b0;
        resp_data_d      = resp_data_q;
        fault_d          = fault_q;
        dmem_req_valid_d = 1'b0;
        dmem_we_d        = dmem_we_q;
        dmem_addr_d      = dmem_addr_q;
        dmem_wdata_d     = dmem_wdata_q;
        dmem_wstrb_d     = dmem_wstrb_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid && (mem_read || mem_write)) begin
                    is_load_d = mem_read && !mem_write;
                    funct3_d  = funct3;
                    addr_lo_d = addr[1:0];
                    if (illegal_c || misaligned_c) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_data_d  = '0;
                        fault_d      = illegal_c ? F_ILLEGAL : F_MISALIGN;
                    end else begin
                        state_d          = S_REQ;
                        dmem_req_valid_d = 1'b1;
                        dmem_we_d        = mem_write;
                        dmem_addr_d      = {addr[ADDR_WIDTH-1:2], 2'b00};
                        dmem_wdata_d     = '0;
                        dmem_wstrb_d     = 4'b0000;
                        if (mem_write) begin
                            case (funct3[1:0])
                                2'b00: begin
                                    dmem_wdata_d = {4{wdata[7:0]}};
                                    dmem_wstrb_d = 4'b0001 << addr[1:0];
                                end
                                2'b01: begin
                                    dmem_wdata_d = {2{wdata[15:0]}};
                                    dmem_wstrb_d = 4'b0011 << addr[1:0];
                                end
                                default: begin
                                    dmem_wdata_d = wdata;
                                    dmem_wstrb_d = 4'b1111;
                                end
                            endcase
                        end
                    end
                end
            end
            S_REQ: begin
                dmem_req_valid_d = 1'b1;
                if (dmem_req_ready) begin
                    dmem_req_valid_d = 1'b0;
                    if (is_load_q) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_data_d  = '0;
                        fault_d      = F_OK;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A response in the limit cycle takes precedence over the timeout
                if (dmem_rsp_valid) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_data_d  = load_ext_c;
                    fault_d      = F_OK;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_data_d  = '0;
                    fault_d      = F_TIMEOUT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        req_ready_d = (state_d == S_IDLE);
        stall_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_IDLE;
            is_load_q        <= 1'b0;
            funct3_q         <= 3'b000;
            addr_lo_q        <= 2'b00;
            cnt_q            <= '0;
            req_ready_q      <= 1'b1;
            stall_q          <= 1'b0;
            resp_valid_q     <= 1'b0;
            resp_data_q      <= '0;
            fault_q          <= F_OK;
            dmem_req_valid_q <= 1'b0;
            dmem_we_q        <= 1'b0;
            dmem_addr_q      <= '0;
            dmem_wdata_q     <= '0;
            dmem_wstrb_q     <= 4'b0000;
        end else begin
            state_q          <= state_d;
            is_load_q        <= is_load_d;
            funct3_q         <= funct3_d;
            addr_lo_q        <= addr_lo_d;
            cnt_q            <= cnt_d;
            req_ready_q      <= req_ready_d;
            stall_q          <= stall_d;
            resp_valid_q     <= resp_valid_d;
            resp_data_q      <= resp_data_d;
            fault_q          <= fault_d;
            dmem_req_valid_q <= dmem_req_valid_d;
            dmem_we_q        <= dmem_we_d;
            dmem_addr_q      <= dmem_addr_d;
            dmem_wdata_q     <= dmem_wdata_d;
            dmem_wstrb_q     <= dmem_wstrb_d;
        end
    end

    assign req_ready      = req_ready_q;
    assign stall          = stall_q;
    assign resp_valid     = resp_valid_q;
    assign resp_data      = resp_data_q;
    assign fault          = fault_q;
    assign dmem_req_valid = dmem_req_valid_q;
    assign dmem_we        = dmem_we_q;
    assign dmem_addr      = dmem_addr_q;
    assign dmem_wdata     = dmem_wdata_q;
    assign dmem_wstrb     = dmem_wstrb_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads, stores, faults, timeout and reset abort,
// with hand-computed expected values and cycle-exact latency checks.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        stall;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [1:0]  fault;
    logic        dmem_req_valid;
    logic        dmem_req_ready = 1'b0;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_rsp_valid = 1'b0;
    logic [31:0] dmem_rdata = '0;

    int checks   = 0;
    int failures = 0;

    load_store_unit #(.TIMEOUT_CYCLES(4), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
        .addr(addr), .wdata(wdata),
        .stall(stall), .resp_valid(resp_valid), .resp_data(resp_data), .fault(fault),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_wstrb(dmem_wstrb), .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for the accept edge; afterwards we sit in cycle +1
    task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        req_valid = 1'b1;
        mem_read  = rd;
        mem_write = wr;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        tick();
        req_valid = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic load_zw(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] rd, input logic [31:0] exp);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        dmem_req_ready = 1'b1;
        issue(1'b1, 1'b0, f3, a, 32'h0);
        check({tag, "_req_valid"}, 32'(dmem_req_valid), 32'd1);
        check({tag, "_addr"}, dmem_addr, wa);
        check({tag, "_wstrb"}, 32'(dmem_wstrb), 32'h0);
        check({tag, "_we"}, 32'(dmem_we), 32'd0);
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = rd;
        tick();
        check({tag, "_no_resp_c2"}, 32'(resp_valid), 32'd0);
        tick();
        dmem_rsp_valid = 1'b0;
        check({tag, "_resp_c3"}, 32'(resp_valid), 32'd1);
        check({tag, "_data"}, resp_data, exp);
        check({tag, "_fault"}, 32'(fault), 32'd0);
        tick();
        check({tag, "_stall_off"}, 32'(stall), 32'd0);
        check({tag, "_data_held"}, resp_data, exp);
    endtask

    task automatic fault_case(input string tag, input logic rd, input logic wr,
                              input logic [2:0] f3, input logic [31:0] a,
                              input logic [1:0] expf);
        issue(rd, wr, f3, a, 32'hDEADBEEF);
        check({tag, "_resp_c1"}, 32'(resp_valid), 32'd1);
        check({tag, "_fault"}, 32'(fault), 32'(expf));
        check({tag, "_no_dmem"}, 32'(dmem_req_valid), 32'd0);
        check({tag, "_data0"}, resp_data, 32'h0);
        tick();
        check({tag, "_idle"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        tick();
        tick();
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_dmem_req_valid", 32'(dmem_req_valid), 32'd0);
        rst = 1'b0;
        tick();

        // Request with neither op is ignored
        req_valid = 1'b1;
        funct3    = 3'b010;
        tick();
        req_valid = 1'b0;
        check("ignore_ready", 32'(req_ready), 32'd1);
        check("ignore_stall", 32'(stall), 32'd0);

        load_zw("lb",  3'b000, 32'h103, 32'h80AABBCC, 32'hFFFFFF80);
        load_zw("lhu", 3'b101, 32'h202, 32'h92345678, 32'h00009234);
        load_zw("lh",  3'b001, 32'h202, 32'h92345678, 32'hFFFF9234);
        load_zw("lbu", 3'b100, 32'h101, 32'h80AABBCC, 32'h000000BB);

        // SB with the memory holding off for three cycles
        dmem_req_ready = 1'b0;
        issue(1'b0, 1'b1, 3'b000, 32'h301, 32'h000000A5);
        for (int i = 0; i < 3; i++) begin
            check("sb_req_valid", 32'(dmem_req_valid), 32'd1);
            check("sb_wdata", dmem_wdata, 32'hA5A5A5A5);
            check("sb_wstrb", 32'(dmem_wstrb), 32'h2);
            check("sb_stall", 32'(stall), 32'd1);
            tick();
        end
        dmem_req_ready = 1'b1;
        check("sb_we", 32'(dmem_we), 32'd1);
        check("sb_addr", dmem_addr, 32'h300);
        tick();
        check("sb_resp", 32'(resp_valid), 32'd1);
        check("sb_data0", resp_data, 32'h0);
        check("sb_fault", 32'(fault), 32'd0);
        tick();
        check("sb_resp_pulse", 32'(resp_valid), 32'd0);

        // SH with zero-wait memory: response two cycles after accept
        issue(1'b0, 1'b1, 3'b001, 32'h302, 32'h1234BEEF);
        check("sh_wdata", dmem_wdata, 32'hBEEFBEEF);
        check("sh_wstrb", 32'(dmem_wstrb), 32'hC);
        check("sh_no_resp_c1", 32'(resp_valid), 32'd0);
        tick();
        check("sh_resp_c2", 32'(resp_valid), 32'd1);
        tick();

        issue(1'b0, 1'b1, 3'b010, 32'h300, 32'hCAFEF00D);
        check("sw_wdata", dmem_wdata, 32'hCAFEF00D);
        check("sw_wstrb", 32'(dmem_wstrb), 32'hF);
        tick();
        tick();

        fault_case("lw_mis",   1'b1, 1'b0, 3'b010, 32'h402, 2'b01);
        fault_case("lh_mis",   1'b1, 1'b0, 3'b001, 32'h401, 2'b01);
        fault_case("rw_ill",   1'b1, 1'b1, 3'b010, 32'h400, 2'b10);
        fault_case("sw_f3ill", 1'b0, 1'b1, 3'b100, 32'h400, 2'b10);
        fault_case("ld_f3ill", 1'b1, 1'b0, 3'b011, 32'h401, 2'b10);

        // LW answered in the 4th WAIT cycle: response beats the timeout
        issue(1'b1, 1'b0, 3'b010, 32'h400, 32'h0);
        tick();
        for (int i = 0; i < 3; i++) begin
            check("lw_late_wait", 32'(resp_valid), 32'd0);
            tick();
        end
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = 32'h12345678;
        tick();
        dmem_rsp_valid = 1'b0;
        check("lw_late_resp", 32'(resp_valid), 32'd1);
        check("lw_late_fault", 32'(fault), 32'd0);
        check("lw_late_data", resp_data, 32'h12345678);
        tick();

        // LW with no response times out after four WAIT cycles
        issue(1'b1, 1'b0, 3'b010, 32'h400, 32'h0);
        tick();
        for (int i = 0; i < 4; i++) begin
            check("to_wait", 32'(resp_valid), 32'd0);
            check("to_stall", 32'(stall), 32'd1);
            tick();
        end
        check("to_resp", 32'(resp_valid), 32'd1);
        check("to_fault", 32'(fault), 32'd3);
        check("to_data0", resp_data, 32'h0);
        tick();

        // Reset during WAIT, then a stale response
        issue(1'b1, 1'b0, 3'b000, 32'h507, 32'h0);
        tick();
        check("ab_in_wait", 32'(stall), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = 32'hFFFFFFFF;
        tick();
        dmem_rsp_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("ab_resp_valid", 32'(resp_valid), 32'd0);
            check("ab_req_ready", 32'(req_ready), 32'd1);
            check("ab_stall", 32'(stall), 32'd0);
            check("ab_fault", 32'(fault), 32'd0);
            check("ab_data", resp_data, 32'h0);
            check("ab_dmem_addr", dmem_addr, 32'h0);
            check("ab_dmem_req", 32'(dmem_req_valid), 32'd0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-side responder for the core's control signals mem_read, mem_write and funct3.
- Accepts one load/store request at a time from the execute stage and checks legality and alignment.
- Issues a word-aligned, byte-strobed transaction on the data-memory port and returns sign- or zero-extended load data.
- Holds a stall to the pipeline until the access completes or faults.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles spent in WAIT before a timeout fault; 0 disables the timeout.
- ADDR_WIDTH, 32: byte address width.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present from the execute stage.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- mem_read  in  1  load request.
- mem_write  in  1  store request.
- funct3  in  3  access size/sign, RV32I encoding.
- addr  in  ADDR_WIDTH  byte address.
- wdata  in  32  store data, right-aligned.
- stall  out  1  high whenever state != IDLE.
- resp_valid  out  1  one-cycle completion pulse.
- resp_data  out  32  extended load data; 0 for stores and faults.
- fault  out  2  00 ok, 01 misaligned, 10 illegal, 11 timeout; valid with resp_valid.
- dmem_req_valid  out  1  memory request.
- dmem_req_ready  in  1  memory accepts the request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  ADDR_WIDTH  addr with bits [1:0] forced to 0.
- dmem_wdata  out  32  wdata replicated into the byte lanes.
- dmem_wstrb  out  4  byte enables; 0000 for reads.
- dmem_rsp_valid  in  1  read data valid.
- dmem_rdata  in  32  read word.

Behaviour:
- Reset: state IDLE; every output 0 except req_ready=1; timeout counter 0.
- Reset mid-operation aborts the access. Any dmem_rsp_valid arriving afterwards is ignored, because responses are sampled only in WAIT.
- States: IDLE, REQ, WAIT, RESP.
- IDLE, with req_valid and (mem_read or mem_write):
  - Capture addr, funct3, wdata and the op.
  - Evaluate faults, highest priority first:
    - illegal: mem_read and mem_write both high; load funct3 in {011,110,111}; store funct3 not in {000,001,010}.
    - misaligned: half with addr[0]=1; word with addr[1:0]!=00.
  - Any fault -> RESP with fault set, and no memory transaction is issued.
  - Otherwise -> REQ.
- IDLE, with req_valid but neither mem_read nor mem_write: ignored.
- REQ:
  - dmem_req_valid=1; address, we, wdata and wstrb held stable until dmem_req_ready.
  - On dmem_req_ready: store -> RESP; load -> WAIT.
- Store lanes:
  - Byte: wdata[7:0] in all four lanes, wstrb = 0001 << addr[1:0].
  - Half: wdata[15:0] in both halves, wstrb = 0011 << addr[1:0].
  - Word: wstrb = 1111.
- WAIT:
  - Counter increments each cycle.
  - On dmem_rsp_valid, select the lane by addr[1:0]:
    - LB/LH sign-extend.
    - LBU/LHU zero-extend.
    - LW passes through.
  - Register the result into resp_data -> RESP.
  - If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES without a response -> RESP with fault=11, resp_data=0.
  - A response arriving in the same cycle the limit is reached wins: fault=00.
- RESP: resp_valid=1 for exactly one cycle -> IDLE. resp_data and fault are held until the next resp_valid.
- Latency from the accept cycle with a zero-wait memory (ready immediately, response the cycle after the request):
  - Fault: resp_valid in cycle +1.
  - Store: +2.
  - Load: +3.
- stall deasserts in the cycle after RESP, when state is IDLE again.

Test Plan:
- LB at addr 0x103 with dmem_rdata=0x80AABBCC -> dmem_addr=0x100, wstrb=0000; resp_data=0xFFFFFF80, fault=00, resp_valid 3 cycles after accept.
- LHU at addr 0x202 with dmem_rdata=0x9234_5678 -> resp_data=0x00009234. Same access as LH -> 0xFFFF9234.
- SB at addr 0x301 with wdata=0x000000A5, dmem_req_ready held low 3 cycles:
  - dmem_wdata=0xA5A5A5A5 and wstrb=0010, both stable while waiting.
  - stall high throughout; resp_valid 1 cycle after ready.
- LW at addr 0x402 -> fault=01 next cycle, no dmem_req_valid. mem_read and mem_write both high -> fault=10. SW with funct3=100 -> fault=10.
- LW with TIMEOUT_CYCLES=4 and no dmem_rsp_valid -> fault=11 after 4 WAIT cycles. A second run with the response in the 4th WAIT cycle -> fault=00 and correct data.
- Reset asserted in WAIT, then dmem_rsp_valid pulsed after reset -> outputs at reset values, no resp_valid, req_ready=1.
